// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: fixed priority with port-1 starvation relief,
// registered memory command, and a two-stage tag pipe that routes read data back to its owner.
module dmem_arbiter #(
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned AW           = 12,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req0_i,
    input  logic          req1_i,
    input  logic          we0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic          gnt0_o,
    output logic          gnt1_o,
    output logic          rvalid0_o,
    output logic          rvalid1_o,
    output logic [DW-1:0] rdata0_o,
    output logic [DW-1:0] rdata1_o,
    output logic          err0_o,
    output logic          err1_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam logic [3:0]    Limit  = 4'(STARVE_LIMIT);
    localparam logic [AW-1:0] DepthW = AW'(DEPTH);

    logic [3:0]    starve_q, starve_d;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          rd1_q, port1_q, err1_q;
    logic          rd2_q, port2_q, err2_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    logic          force1, grant, sel_we, in_range;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    always_comb begin
        force1    = req1_i && (starve_q == Limit);
        gnt1_o    = !rst_i && req1_i && (!req0_i || force1);
        gnt0_o    = !rst_i && req0_i && !force1;
        grant     = gnt0_o || gnt1_o;
        sel_we    = gnt1_o ? we1_i : we0_i;
        sel_addr  = gnt1_o ? addr1_i : addr0_i;
        sel_wdata = gnt1_o ? wdata1_i : wdata0_i;
        in_range  = sel_addr < DepthW;

        starve_d = starve_q;
        if (!req1_i || gnt1_o) begin
            starve_d = '0;
        end else if (gnt0_o && starve_q < Limit) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd1_q       <= 1'b0;
            port1_q     <= 1'b0;
            err1_q      <= 1'b0;
            rd2_q       <= 1'b0;
            port2_q     <= 1'b0;
            err2_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            starve_q <= starve_d;
            // Out-of-range grants leave the memory command untouched apart from dropping we.
            mem_we_q <= grant && in_range && sel_we;
            if (grant && in_range) begin
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
            end
            rd1_q    <= grant && in_range && !sel_we;
            port1_q  <= gnt1_o;
            err1_q   <= grant && !in_range;
            rd2_q    <= rd1_q;
            port2_q  <= port1_q;
            err2_q   <= err1_q;
            rdata0_q <= rdata0_o;
            rdata1_q <= rdata1_o;
        end
    end

    always_comb begin
        rvalid0_o   = !rst_i && rd2_q && !port2_q;
        rvalid1_o   = !rst_i && rd2_q && port2_q;
        err0_o      = !rst_i && err2_q && !port2_q;
        err1_o      = !rst_i && err2_q && port2_q;
        rdata0_o    = rst_i ? '0 : (rvalid0_o ? mem_rdata_i : rdata0_q);
        rdata1_o    = rst_i ? '0 : (rvalid1_o ? mem_rdata_i : rdata1_q);
        mem_we_o    = mem_we_q;
        mem_addr_o  = mem_addr_q;
        mem_wdata_o = mem_wdata_q;
    end

endmodule
